// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline widths, fetch record type and the NOP instruction used by ID
package pipe_pkg;
    localparam int PC_W = 32;
    localparam int INSTR_W = 32;
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_t;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'b0;
endpackage

// File: rtl/ifq_mem.sv
// ifq_mem: DEPTH x W register array, synchronous write, asynchronous read
// Ports: clk; we/waddr/wdata write port; raddr/rdata combinational read port
module ifq_mem #(
    parameter int DEPTH = 4,
    parameter int W = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);
    logic [W-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: in-order IF->ID instruction queue with valid/ready handshakes and branch flush
// Ports: clk; rst (sync, active-low); flush; in_valid/in_pc/in_instr/in_ready from IF;
//        out_valid/out_pc/out_instr/out_ready to ID; count = occupancy.
// Build option IFQ_BYPASS_EN: an empty queue passes IF's fetch straight to ID combinationally.
module if_id_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W = 32,
    parameter int INSTR_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [PC_W-1:0]            in_pc,
    input  logic [INSTR_W-1:0]         in_instr,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [PC_W-1:0]            out_pc,
    output logic [INSTR_W-1:0]         out_instr,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    import pipe_pkg::*;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int W = PC_W + INSTR_W;
    // Pointers carry one extra wrap bit so full and empty are distinguishable
    logic [AW:0]  wr_ptr, rd_ptr;
    logic         empty, full, push, pop, bypass;
    logic [W-1:0] head;
    assign empty = wr_ptr == rd_ptr;
    assign full = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign in_ready = ~full;
    assign count = CW'(wr_ptr - rd_ptr);
`ifdef IFQ_BYPASS_EN
    // A fetch consumed by ID in the same cycle never touches storage
    assign bypass = empty & ~flush & in_valid & out_ready;
    assign out_valid = ~flush & (~empty | in_valid);
    assign out_pc = empty ? in_pc : head[W-1:INSTR_W];
    assign out_instr = empty ? in_instr : head[INSTR_W-1:0];
`else
    assign bypass = 1'b0;
    assign out_valid = ~empty;
    assign out_pc = empty ? '0 : head[W-1:INSTR_W];
    assign out_instr = empty ? INSTR_W'(NOP_INSTR) : head[INSTR_W-1:0];
`endif
    assign push = in_valid & in_ready & ~flush & ~bypass;
    assign pop = ~empty & out_ready & ~flush;
    ifq_mem #(.DEPTH(DEPTH), .W(W)) u_mem (
        .clk(clk),
        .we(push),
        .waddr(wr_ptr[AW-1:0]),
        .wdata({in_pc, in_instr}),
        .raddr(rd_ptr[AW-1:0]),
        .rdata(head)
    );
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: randomized and directed stimulus against a queue-based reference model with scoreboard
module tb_if_id_queue;
    import pipe_pkg::*;
    localparam int DEPTH = 4;
    logic        clk = 0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_pc, in_instr, out_pc, out_instr;
    logic [2:0]  count;
    int          checks = 0;
    int          failures = 0;
    bit          armed = 0;
    fetch_t      exp_q[$];

    if_id_queue #(.DEPTH(DEPTH), .PC_W(32), .INSTR_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ready(in_ready),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_ready(out_ready),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Monitor: outputs are sampled on the falling edge, halfway between input changes and the active edge
    always @(negedge clk) begin
        int n;
        fetch_t e;
        n = exp_q.size();
        if (armed) begin
            check("count", 64'(count), 64'(n));
            check("in_ready", 64'(in_ready), 64'(n < DEPTH));
            check("out_valid", 64'(out_valid), 64'(n > 0));
            if (n == 0) begin
                check("empty_pc", 64'(out_pc), 64'd0);
                check("empty_instr", 64'(out_instr), 64'd0);
            end
            if (out_valid && out_ready && !flush && rst) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 64'(out_pc), 64'hffff_ffff_ffff_ffff);
                end else begin
                    e = exp_q.pop_front();
                    check("out_pc", 64'(out_pc), 64'(e.pc));
                    check("out_instr", 64'(out_instr), 64'(e.instr));
                end
            end
        end
        if (!rst) begin
            exp_q.delete();
            armed = 1;
        end else if (armed) begin
            if (flush) exp_q.delete();
            else if (in_valid && n < DEPTH) exp_q.push_back('{pc: in_pc, instr: in_instr});
        end
    end

    task automatic step(input logic r, input logic f, input logic v,
                        input logic [31:0] pc, input logic [31:0] ins, input logic o);
        rst = r;
        flush = f;
        in_valid = v;
        in_pc = pc;
        in_instr = ins;
        out_ready = o;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int bias;
        // Reset held for two cycles while IF offers a fetch
        step(0, 0, 1, 32'hdead, 32'hbeef, 0);
        step(0, 0, 1, 32'hdead, 32'hbeef, 0);
        step(1, 0, 0, 0, 0, 0);
        check("reset_count", 64'(count), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        // Fill with ID frozen, fifth push must bounce, then drain in order
        for (int i = 1; i <= 5; i++) step(1, 0, 1, 32'(i), 32'h0022_1000 + 32'(i - 1), 0);
        check("full_count", 64'(count), 64'd4);
        check("full_in_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 1);
        // Wrap: push 3, pop 3, push 4, pop 4
        for (int i = 0; i < 3; i++) step(1, 0, 1, 32'(100 + i), 32'(200 + i), 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 0, 1, 32'(110 + i), 32'(210 + i), 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 1);
        // Streaming
        for (int i = 0; i < 10; i++) step(1, 0, 1, 32'(300 + i), 32'(400 + i), 1);
        check("stream_count", 64'(count), 64'd1);
        for (int i = 0; i < 2; i++) step(1, 0, 0, 0, 0, 1);
        // Flush with three queued and a concurrent push of PC 9
        for (int i = 0; i < 3; i++) step(1, 0, 1, 32'(30 + i), 32'(40 + i), 0);
        step(1, 1, 1, 32'd9, 32'h9, 0);
        check("flush_count", 64'(count), 64'd0);
        step(1, 0, 1, 32'd20, 32'h20, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 1);
        // Freeze hold: PC 5 at head while pushing with ID frozen
        step(1, 0, 1, 32'd5, 32'h5, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 1, 32'(6 + i), 32'(6 + i), 0);
            check("freeze_pc", 64'(out_pc), 64'd5);
        end
        check("freeze_count", 64'(count), 64'd4);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 1);
        // Randomized traffic with occasional flush and reset, shifting the consume bias
        for (int i = 0; i < 3000; i++) begin
            bias = (i < 1000) ? 1 : (i < 2000) ? 3 : 2;
            step($urandom_range(99) != 0, $urandom_range(15) == 0, 1'($urandom_range(1)),
                 $urandom, $urandom, $urandom_range(3) < bias);
        end
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
